// File: rtl/axi_reg_master.sv
// Register-interface initiator for AXI_top: turns single read/write requests into the
// address/data setup, one-cycle cmd pulse, NOP release sequence and returns the response.
package AXI_package;
    localparam int REG_WIDTH = 32;
    localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'd2;
endpackage

module axi_reg_master
    import AXI_package::*;
#(
    parameter bit                   VERIFY       = 1'b1,
    parameter logic [REG_WIDTH-1:0] READ_MASK    = 32'h0000_FFFF,
    parameter int                   READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [REG_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0] req_data,
    output logic                 rsp_valid,
    output logic [REG_WIDTH-1:0] rsp_data,
    output logic                 rsp_error,
    output logic                 busy,
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] cmd_register,
    input  logic [REG_WIDTH-1:0] data_o_register
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ISSUE, S_RELEASE, S_WAIT, S_RESP
    } state_e;

    localparam int WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int CNT_W     = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    logic                 verify_q, verify_d;
    logic [REG_WIDTH-1:0] expected_q, expected_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [REG_WIDTH-1:0] address_q, address_d;
    logic [REG_WIDTH-1:0] data_in_q, data_in_d;
    logic [REG_WIDTH-1:0] cmd_q, cmd_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 capture;

    assign req_ready        = (state_q == S_IDLE) && !rst;
    assign busy             = !req_ready;
    assign address_register = address_q;
    assign data_in_register = data_in_q;
    assign cmd_register     = cmd_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_error        = rsp_error_q;

    // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        verify_d    = verify_q;
        expected_d  = expected_q;
        wait_cnt_d  = wait_cnt_q;
        address_d   = address_q;
        data_in_d   = data_in_q;
        cmd_d       = cmd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    address_d  = req_addr;
                    if (req_write) data_in_d = req_data;
                    write_d    = req_write;
                    verify_d   = 1'b0;
                    expected_d = req_data & READ_MASK;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cmd_d   = write_q ? CMD_WRITE : CMD_READ;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_d   = CMD_NOP;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // The write phase of a transaction either finishes here or turns into a read-back.
                if (write_q && !verify_q) begin
                    if (VERIFY) begin
                        verify_d = 1'b1;
                        cmd_d    = CMD_READ;
                        state_d  = S_ISSUE;
                    end else begin
                        rsp_error_d = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end else if (READ_LATENCY > 1) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == CNT_W'(WAIT_LAST)) capture = 1'b1;
                else wait_cnt_d = wait_cnt_q + 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            rsp_data_d  = data_o_register & READ_MASK;
            rsp_error_d = verify_q && ((data_o_register & READ_MASK) != expected_q);
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            verify_q    <= 1'b0;
            expected_q  <= '0;
            wait_cnt_q  <= '0;
            address_q   <= '0;
            data_in_q   <= '0;
            cmd_q       <= CMD_NOP;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            verify_q    <= verify_d;
            expected_q  <= expected_d;
            wait_cnt_q  <= wait_cnt_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

endmodule
